// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin controller that shares one combinational alu
// between two requesters. Each accepted op is driven into the alu from
// registers. The alu output is captured one cycle later and returned on the
// winning requester's response channel. An architectural flag register
// tracks the flags of the last completed op, including TST.
module alu_share_ctrl #(
    parameter int W      = 16,
    parameter int OP_W   = 5,
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    // requester 0
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [W-1:0]      req0_a,
    input  logic [W-1:0]      req0_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    // requester 1
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [W-1:0]      req1_a,
    input  logic [W-1:0]      req1_b,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    // shared response payload
    output logic [W-1:0]      rsp_result,
    output logic [FLAG_W-1:0] rsp_flags,
    // alu interface
    output logic [OP_W-1:0]   alu_op,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    input  logic [W-1:0]      alu_result,
    input  logic [FLAG_W-1:0] alu_flags,
    // status
    output logic [FLAG_W-1:0] flags_q,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                prio_q, prio_d;
    logic                gnt_q, gnt_d;
    logic [OP_W-1:0]     alu_op_q, alu_op_d;
    logic [W-1:0]        alu_a_q, alu_a_d;
    logic [W-1:0]        alu_b_q, alu_b_d;
    logic [W-1:0]        rsp_result_q, rsp_result_d;
    logic [FLAG_W-1:0]   rsp_flags_q, rsp_flags_d;
    logic [FLAG_W-1:0]   arch_flags_q, arch_flags_d;

    logic                any_valid_s;
    logic                win1_s;
    logic                rsp_taken_s;

    // Arbitration: requester 1 wins when it is the only one valid, or when both are valid and it holds priority.
    always_comb begin
        any_valid_s = req0_valid | req1_valid;
        win1_s      = req1_valid & (~req0_valid | prio_q);
        rsp_taken_s = gnt_q ? rsp1_ready : rsp0_ready;
    end

    // State, priority and datapath registers; async reset discards any in-flight op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            prio_q       <= 1'b0;
            gnt_q        <= 1'b0;
            alu_op_q     <= {OP_W{1'b0}};
            alu_a_q      <= {W{1'b0}};
            alu_b_q      <= {W{1'b0}};
            rsp_result_q <= {W{1'b0}};
            rsp_flags_q  <= {FLAG_W{1'b0}};
            arch_flags_q <= {FLAG_W{1'b0}};
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            gnt_q        <= gnt_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            arch_flags_q <= arch_flags_d;
        end
    end

    // Next-state logic: accept in IDLE, capture in EXEC, wait for consumption in RESP.
    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        gnt_d        = gnt_q;
        alu_op_d     = alu_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        arch_flags_d = arch_flags_q;
        case (state_q)
            S_IDLE: begin
                if (any_valid_s) begin
                    state_d = S_EXEC;
                    gnt_d   = win1_s;
                    if (win1_s) begin
                        alu_op_d = req1_op;
                        alu_a_d  = req1_a;
                        alu_b_d  = req1_b;
                    end else begin
                        alu_op_d = req0_op;
                        alu_a_d  = req0_a;
                        alu_b_d  = req0_b;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                state_d      = S_RESP;
                rsp_result_d = alu_result;
                rsp_flags_d  = alu_flags;
                arch_flags_d = alu_flags;
            end
            S_RESP: begin
                if (rsp_taken_s) begin
                    state_d = S_IDLE;
                    prio_d  = ~gnt_q;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode: ready only in IDLE for the winner, rsp_valid only in RESP for the granted port.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        busy       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rst && any_valid_s) begin
                    req0_ready = ~win1_s;
                    req1_ready = win1_s;
                end else begin
                    req0_ready = 1'b0;
                    req1_ready = 1'b0;
                end
            end
            S_EXEC: begin
                busy = 1'b1;
            end
            S_RESP: begin
                busy       = 1'b1;
                rsp0_valid = ~gnt_q;
                rsp1_valid = gnt_q;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign alu_op     = alu_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign flags_q    = arch_flags_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl. A behavioural alu drives the
// alu_result/alu_flags inputs; the reference model tracks the round-robin
// priority and the expected response per transaction.
module tb_alu_share_ctrl;

    localparam int W      = 16;
    localparam int OP_W   = 5;
    localparam int FLAG_W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
    logic [OP_W-1:0]   req_op [2];
    logic [W-1:0]      req_a  [2];
    logic [W-1:0]      req_b  [2];
    logic [W-1:0]      rsp_result, alu_a, alu_b, alu_result;
    logic [FLAG_W-1:0] rsp_flags, alu_flags, flags_q;
    logic [OP_W-1:0]   alu_op;
    logic              busy;

    int   total = 0;
    int   bad   = 0;
    logic prio_m;

    // Behavioural alu: {N,Z,C,V} flags; TST returns a&b with flags of a-b.
    function automatic logic [FLAG_W+W-1:0] alu_fn(input logic [OP_W-1:0] op,
                                                   input logic [W-1:0] a,
                                                   input logic [W-1:0] b);
        logic [W:0]   s;
        logic [W-1:0] r, f;
        logic         c, v;
        s = '0; c = 1'b0; v = 1'b0;
        case (op)
            5'd0: begin
                s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            5'd1, 5'd15: begin
                s = {1'b0, a} - {1'b0, b}; r = s[W-1:0]; c = s[W];
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            5'd2:    r = a & b;
            5'd3:    r = a | b;
            5'd4:    r = a ^ b;
            default: r = ~(a ^ b);
        endcase
        f = (op == 5'd15) ? s[W-1:0] : r;
        if (op == 5'd15) r = a & b;
        return {f[W-1], (f == '0), c, v, r};
    endfunction

    assign {alu_flags, alu_result} = alu_fn(alu_op, alu_a, alu_b);

    alu_share_ctrl #(.W(W), .OP_W(OP_W), .FLAG_W(FLAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req_valid[0]),
        .req0_ready (req_ready[0]),
        .req0_op    (req_op[0]),
        .req0_a     (req_a[0]),
        .req0_b     (req_b[0]),
        .rsp0_valid (rsp_valid[0]),
        .rsp0_ready (rsp_ready[0]),
        .req1_valid (req_valid[1]),
        .req1_ready (req_ready[1]),
        .req1_op    (req_op[1]),
        .req1_a     (req_a[1]),
        .req1_b     (req_b[1]),
        .rsp1_valid (rsp_valid[1]),
        .rsp1_ready (rsp_ready[1]),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .flags_q    (flags_q),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic post(input int n, input logic [OP_W-1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid[n] = 1'b1;
        req_op[n]    = op;
        req_a[n]     = a;
        req_b[n]     = b;
    endtask

    // Asserts reset, checks every output is cleared, then releases it.
    task automatic do_reset();
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        rst = 1'b1;
        #1;
        check("rst_ready",   {30'd0, req_ready}, 32'd0);
        check("rst_rspv",    {30'd0, rsp_valid}, 32'd0);
        check("rst_result",  {16'd0, rsp_result}, 32'd0);
        check("rst_flags",   {28'd0, rsp_flags}, 32'd0);
        check("rst_alu",     {alu_a, alu_b}, 32'd0);
        check("rst_aluop",   {27'd0, alu_op}, 32'd0);
        check("rst_flagsq",  {28'd0, flags_q}, 32'd0);
        check("rst_busy",    {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        prio_m = 1'b0;
    endtask

    // Runs one transaction for the expected winner w (request already posted), holding the response d extra cycles.
    task automatic run_txn(input int w, input int d);
        int o;
        logic [OP_W-1:0] op;
        logic [W-1:0] a, b;
        logic [FLAG_W+W-1:0] e;
        o  = 1 - w;
        op = req_op[w]; a = req_a[w]; b = req_b[w];
        e  = alu_fn(op, a, b);
        check("accept_ready_w", {31'd0, req_ready[w]}, 32'd1);
        check("accept_ready_o", {31'd0, req_ready[o]}, 32'd0);
        check("accept_busy",    {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        req_valid[w] = 1'b0;
        check("exec_busy", {31'd0, busy}, 32'd1);
        check("exec_rspv", {30'd0, rsp_valid}, 32'd0);
        check("exec_alu",  {alu_a, alu_b}, {a, b});
        check("exec_op",   {27'd0, alu_op}, {27'd0, op});
        @(posedge clk); #1;
        check("resp_valid_w", {31'd0, rsp_valid[w]}, 32'd1);
        check("resp_valid_o", {31'd0, rsp_valid[o]}, 32'd0);
        check("resp_result",  {16'd0, rsp_result}, {16'd0, e[W-1:0]});
        check("resp_flags",   {28'd0, rsp_flags}, {28'd0, e[FLAG_W+W-1:W]});
        check("resp_flagsq",  {28'd0, flags_q}, {28'd0, e[FLAG_W+W-1:W]});
        for (int i = 0; i < d; i++) begin
            @(posedge clk); #1;
            check("hold_valid",  {31'd0, rsp_valid[w]}, 32'd1);
            check("hold_result", {12'd0, rsp_flags, rsp_result}, {12'd0, e});
            check("hold_ready",  {30'd0, req_ready}, 32'd0);
            check("hold_busy",   {31'd0, busy}, 32'd1);
        end
        rsp_ready[w] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[w] = 1'b0;
        prio_m = (w == 0);
        check("done_busy",   {31'd0, busy}, 32'd0);
        check("done_rspv",   {30'd0, rsp_valid}, 32'd0);
        check("done_alu",    {alu_a, alu_b}, {a, b});
        check("done_flagsq", {28'd0, flags_q}, {28'd0, e[FLAG_W+W-1:W]});
    endtask

    // Posts requests for the ports in mask and serves them in model round-robin order.
    task automatic run_round(input logic [1:0] mask_in, input int dmax);
        logic [1:0] mask;
        int w;
        mask = mask_in;
        for (int n = 0; n < 2; n++)
            if (mask[n])
                post(n, OP_W'($urandom_range(0, 31)), W'($urandom), W'($urandom));
        #1;
        while (mask != 2'b00) begin
            w = (mask == 2'b11) ? int'(prio_m) : (mask[0] ? 0 : 1);
            run_txn(w, $urandom_range(0, dmax));
            mask[w] = 1'b0;
        end
    endtask

    initial begin
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        for (int n = 0; n < 2; n++) begin
            req_op[n] = '0; req_a[n] = '0; req_b[n] = '0;
        end
        rst = 1'b1;
        prio_m = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // T1: reset during EXEC drops the op
        post(0, 5'd0, 16'd100, 16'd23);
        #1;
        check("t1_ready", {31'd0, req_ready[0]}, 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        check("t1_exec_busy", {31'd0, busy}, 32'd1);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("t1_no_rsp", {29'd0, busy, rsp_valid}, 32'd0);
        end

        // T2: TST from requester 0
        post(0, 5'b01111, -16'sd32, 16'sd5);
        #1;
        run_txn(0, 0);

        // T3: simultaneous requests after reset, twice
        do_reset();
        post(0, 5'd0, 16'd7, 16'd8);
        post(1, 5'd1, 16'd7, 16'd8);
        #1;
        run_txn(0, 1);
        run_txn(1, 0);
        post(0, 5'd2, 16'hF0F0, 16'h0FF0);
        post(1, 5'd4, 16'h1234, 16'h00FF);
        #1;
        run_txn(0, 0);
        run_txn(1, 2);

        // T4: req1 TST with held response while req0 waits
        post(0, 5'd3, 16'd1, 16'd2);
        #1;
        run_txn(0, 0);
        post(1, 5'b01111, 16'sd9, -16'sd1);
        post(0, 5'd0, 16'd40, 16'd2);
        #1;
        run_txn(1, 5);
        run_txn(0, 0);

        // T5: back-to-back ops from req0
        post(0, 5'd0, 16'sd16, 16'sd11);
        #1;
        run_txn(0, 0);
        post(0, 5'd0, -16'sd13, -16'sd3);
        #1;
        run_txn(0, 0);
        @(posedge clk); #1;
        check("t5_idle_alu", {alu_a, alu_b}, {-16'sd13, -16'sd3});

        // Randomized rounds against the reference model
        for (int r = 0; r < 40; r++)
            run_round(2'($urandom_range(1, 3)), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
